// File: rtl/sdith_verify_pkg.sv
// Shared constants, FSM state type and sizing helpers for the SDitH verifier leaf datapath.
package sdith_verify_pkg;

    localparam int unsigned D_HYPERCUBE = 8;
    localparam int unsigned NODE_W      = 9;
    localparam int unsigned LVL_W       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StZero
    } spl_state_e;

    function automatic int unsigned lambda_of(input logic [15:0] param_set);
        if (param_set == "L3") return 192;
        if (param_set == "L5") return 256;
        return 128;
    endfunction

    function automatic int unsigned wps_of(input int unsigned seed_size);
        return seed_size / 32;
    endfunction

    function automatic int unsigned aw_of(input int unsigned wps);
        return $clog2(D_HYPERCUBE * wps);
    endfunction

endpackage

// File: rtl/sibling_path_loader_if.sv
// Stream-in / path-RAM-out bundle of the sibling path loader; names are from the loader's view.
interface sibling_path_loader_if #(
    parameter int unsigned AW = 5
) ();

    logic          i_start;
    logic [7:0]    i_i_star;
    logic [31:0]   i_data;
    logic          i_data_valid;
    logic          i_clear;
    logic          o_data_ready;
    logic [31:0]   o_path_seed;
    logic [AW-1:0] o_path_addr;
    logic          o_path_wen;
    logic [8:0]    o_node_idx;
    logic [3:0]    o_node_level;
    logic          o_node_wen;
    logic          o_busy;
    logic          o_done;

    modport slave (
        input  i_start, i_i_star, i_data, i_data_valid, i_clear,
        output o_data_ready, o_path_seed, o_path_addr, o_path_wen,
               o_node_idx, o_node_level, o_node_wen, o_busy, o_done
    );

    modport master (
        output i_start, i_i_star, i_data, i_data_valid, i_clear,
        input  o_data_ready, o_path_seed, o_path_addr, o_path_wen,
               o_node_idx, o_node_level, o_node_wen, o_busy, o_done
    );

endinterface

// File: rtl/sibling_node_index.sv
// Combinational heap index of the sibling node at tree level i_lvl on the path to leaf i_star.
module sibling_node_index
    import sdith_verify_pkg::*;
(
    input  logic [7:0]        i_i_star,
    input  logic [LVL_W-1:0]  i_lvl,
    output logic [NODE_W-1:0] o_node_idx
);

    logic [NODE_W-1:0] w_leaf;
    logic [LVL_W-1:0]  w_shift;

    // Leaves sit at heap index 256 + i_star; the ancestor at lvl is a right shift.
    assign w_leaf     = {1'b1, i_i_star};
    assign w_shift    = LVL_W'(D_HYPERCUBE) - i_lvl;
    assign o_node_idx = (w_leaf >> w_shift) ^ NODE_W'(1);

endmodule

// File: rtl/sibling_path_loader.sv
// Loads the D_HYPERCUBE sibling-path seeds into the path RAM and publishes sibling heap indices.
// Optional zeroize of the path RAM is compiled in with SIBLING_PATH_ZEROIZE_EN.
module sibling_path_loader
    import sdith_verify_pkg::*;
#(
    parameter logic [15:0] PARAMETER_SET = "L1",
    parameter int unsigned SEED_SIZE     = lambda_of(PARAMETER_SET),
    parameter int unsigned WPS           = wps_of(SEED_SIZE),
    parameter int unsigned AW            = aw_of(WPS)
) (
    input logic                  i_clk,
    input logic                  i_rst,
    sibling_path_loader_if.slave bus
);

    localparam int unsigned NWORDS = D_HYPERCUBE * WPS;

    spl_state_e        r_state;
    logic [7:0]        r_i_star;
    logic [LVL_W-1:0]  r_lvl;
    logic [3:0]        r_w;
    logic [AW-1:0]     r_waddr;
    logic              r_ready;
    logic [31:0]       r_path_seed;
    logic [AW-1:0]     r_path_addr;
    logic              r_path_wen;
    logic [NODE_W-1:0] r_node_idx;
    logic [LVL_W-1:0]  r_node_level;
    logic              r_node_wen;
    logic              r_busy;
    logic              r_done;

    logic [NODE_W-1:0] w_node_idx;
    logic              w_hs;
    logic              w_last_word;
    logic              w_last_lvl;
    logic              w_start_take;
    logic              w_clear_take;

    // r_ready is only ever high in StLoad, so it doubles as the state qualifier.
    assign w_hs         = r_ready & bus.i_data_valid;
    assign w_last_word  = (r_w == 4'(WPS - 1));
    assign w_last_lvl   = (r_lvl == LVL_W'(D_HYPERCUBE));
    assign w_start_take = (r_state == StIdle) & bus.i_start;

`ifdef SIBLING_PATH_ZEROIZE_EN
    assign w_clear_take = (r_state == StIdle) & ~bus.i_start & bus.i_clear;
`else
    logic w_unused_clear;
    assign w_unused_clear = bus.i_clear;
    assign w_clear_take   = 1'b0;
`endif

    sibling_node_index u_node_index (
        .i_i_star   (r_i_star),
        .i_lvl      (r_lvl),
        .o_node_idx (w_node_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_i_star     <= '0;
            r_lvl        <= '0;
            r_w          <= '0;
            r_waddr      <= '0;
            r_ready      <= 1'b0;
            r_path_seed  <= '0;
            r_path_addr  <= '0;
            r_path_wen   <= 1'b0;
            r_node_idx   <= '0;
            r_node_level <= '0;
            r_node_wen   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_path_wen <= 1'b0;
            r_node_wen <= 1'b0;
            r_done     <= 1'b0;
            // Stays high through the FLUSH/done cycle, drops once back in IDLE.
            r_busy     <= (r_state != StIdle) | w_start_take | w_clear_take;

            unique case (r_state)
                StIdle: begin
                    if (w_start_take) begin
                        r_i_star <= bus.i_i_star;
                        r_lvl    <= LVL_W'(1);
                        r_w      <= '0;
                        r_waddr  <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= StLoad;
                    end else if (w_clear_take) begin
                        r_waddr  <= '0;
                        r_state  <= StZero;
                    end
                end

                StLoad: begin
                    if (w_hs) begin
                        r_path_wen  <= 1'b1;
                        r_path_seed <= bus.i_data;
                        r_path_addr <= r_waddr;
                        r_waddr     <= r_waddr + AW'(1);
                        if (r_w == 4'd0) begin
                            r_node_wen   <= 1'b1;
                            r_node_idx   <= w_node_idx;
                            r_node_level <= r_lvl;
                        end
                        if (w_last_word) begin
                            r_w   <= '0;
                            r_lvl <= r_lvl + LVL_W'(1);
                        end else begin
                            r_w   <= r_w + 4'd1;
                        end
                        if (w_last_word && w_last_lvl) begin
                            r_ready <= 1'b0;
                            r_state <= StFlush;
                        end
                    end
                end

                StFlush: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end

                StZero: begin
`ifdef SIBLING_PATH_ZEROIZE_EN
                    r_path_wen  <= 1'b1;
                    r_path_seed <= '0;
                    r_path_addr <= r_waddr;
                    r_waddr     <= r_waddr + AW'(1);
                    if (r_waddr == AW'(NWORDS - 1)) begin
                        r_state <= StFlush;
                    end
`else
                    r_state <= StIdle;
`endif
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_data_ready = r_ready;
    assign bus.o_path_seed  = r_path_seed;
    assign bus.o_path_addr  = r_path_addr;
    assign bus.o_path_wen   = r_path_wen;
    assign bus.o_node_idx   = r_node_idx;
    assign bus.o_node_level = r_node_level;
    assign bus.o_node_wen   = r_node_wen;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;

endmodule

// File: tb/tb_sibling_path_loader.sv
// Self-checking bench for sibling_path_loader: L1, L5 and L3 instances share one stimulus stream.
module tb_sibling_path_loader;
    import sdith_verify_pkg::*;

    localparam int unsigned WPS1 = wps_of(lambda_of("L1"));
    localparam int unsigned WPS5 = wps_of(lambda_of("L5"));
    localparam int unsigned WPS3 = wps_of(lambda_of("L3"));
    localparam int unsigned AW1  = aw_of(WPS1);
    localparam int unsigned AW5  = aw_of(WPS5);
    localparam int unsigned AW3  = aw_of(WPS3);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start5 = 1'b0, start3 = 1'b0;
    logic        clear1 = 1'b0, clear5 = 1'b0, clear3 = 1'b0;
    logic [7:0]  istar_d = '0;
    logic [31:0] data_d = '0;
    logic        valid_d = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 1;
    int cyc = 0;

    // Monitor state: appended only by the monitor process.
    int          wr_addr_q[$];
    logic [31:0] wr_seed_q[$];
    int          nd_idx_q[$];
    int          nd_lvl_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    int          busy3_cnt = 0;

    always #5 clk = ~clk;

    sibling_path_loader_if #(.AW(AW1)) bus1 ();
    sibling_path_loader_if #(.AW(AW5)) bus5 ();
    sibling_path_loader_if #(.AW(AW3)) bus3 ();

    assign bus1.i_start = start1;  assign bus1.i_clear = clear1;  assign bus1.i_i_star = istar_d;
    assign bus1.i_data  = data_d;  assign bus1.i_data_valid = valid_d;
    assign bus5.i_start = start5;  assign bus5.i_clear = clear5;  assign bus5.i_i_star = istar_d;
    assign bus5.i_data  = data_d;  assign bus5.i_data_valid = valid_d;
    assign bus3.i_start = start3;  assign bus3.i_clear = clear3;  assign bus3.i_i_star = istar_d;
    assign bus3.i_data  = data_d;  assign bus3.i_data_valid = valid_d;

    sibling_path_loader #(.PARAMETER_SET("L1")) u_dut_l1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    sibling_path_loader #(.PARAMETER_SET("L5")) u_dut_l5 (.i_clk(clk), .i_rst(rst), .bus(bus5));
    sibling_path_loader #(.PARAMETER_SET("L3")) u_dut_l3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

    always @(posedge clk) begin
        cyc++;
        #2;
        if (bus1.o_path_wen) begin
            wr_addr_q.push_back(int'(bus1.o_path_addr)); wr_seed_q.push_back(bus1.o_path_seed);
            last_wr_cyc = cyc;
        end
        if (bus5.o_path_wen) begin
            wr_addr_q.push_back(int'(bus5.o_path_addr)); wr_seed_q.push_back(bus5.o_path_seed);
            last_wr_cyc = cyc;
        end
        if (bus3.o_path_wen) begin
            wr_addr_q.push_back(int'(bus3.o_path_addr)); wr_seed_q.push_back(bus3.o_path_seed);
            last_wr_cyc = cyc;
        end
        if (bus1.o_node_wen) begin
            nd_idx_q.push_back(int'(bus1.o_node_idx)); nd_lvl_q.push_back(int'(bus1.o_node_level));
        end
        if (bus5.o_node_wen) begin
            nd_idx_q.push_back(int'(bus5.o_node_idx)); nd_lvl_q.push_back(int'(bus5.o_node_level));
        end
        if (bus3.o_node_wen) begin
            nd_idx_q.push_back(int'(bus3.o_node_idx)); nd_lvl_q.push_back(int'(bus3.o_node_level));
        end
        if (bus1.o_done || bus5.o_done || bus3.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus3.o_busy) busy3_cnt++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: sibling of the depth-lvl ancestor of leaf (256 + i_star) in a 1-based heap.
    function automatic int model_node(input int istar, input int lvl);
        int anc;
        anc = (256 + istar) / (1 << (8 - lvl));
        return (anc % 2 == 0) ? anc + 1 : anc - 1;
    endfunction

    function automatic int wps_sel(input int s);
        return (s == 1) ? int'(WPS1) : (s == 5) ? int'(WPS5) : int'(WPS3);
    endfunction

    function automatic logic cur_ready();
        case (sel)
            1:       return bus1.o_data_ready;
            5:       return bus5.o_data_ready;
            default: return bus3.o_data_ready;
        endcase
    endfunction

    function automatic logic cur_busy();
        case (sel)
            1:       return bus1.o_busy;
            5:       return bus5.o_busy;
            default: return bus3.o_busy;
        endcase
    endfunction

    function automatic void set_start(input logic b);
        start1 = (sel == 1) ? b : 1'b0;
        start5 = (sel == 5) ? b : 1'b0;
        start3 = (sel == 3) ? b : 1'b0;
    endfunction

    task automatic send_words(input int n, input int gapmax, input logic [31:0] base, input int poke);
        int gap;
        int guard;
        for (int k = 0; k < n; k++) begin
            gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (gap) begin
                valid_d = 1'b0; data_d = $urandom;
                @(negedge clk);
            end
            data_d = base + 32'(k); valid_d = 1'b1;
            set_start(k == poke);
            guard = 0;
            while (!cur_ready() && guard < 50) begin
                @(negedge clk); set_start(1'b0); guard++;
            end
            if (guard >= 50) begin
                check("ready_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            set_start(1'b0);
        end
        valid_d = 1'b0;
    endtask

    task automatic wait_done(input int dn0);
        int g;
        g = 0;
        while (done_cnt == dn0 && g < 100) begin
            @(negedge clk); g++;
        end
        if (done_cnt == dn0) check("done_timeout", 0, 1);
    endtask

    // Starts a load on DUT s (optionally with i_clear in the same cycle) and streams the path.
    task automatic run_load(input int s, input logic [7:0] istar, input int gapmax,
                            input logic [31:0] base, input int poke, input logic clr,
                            output int sc);
        int dn0;
        sel = s;
        dn0 = done_cnt;
        @(negedge clk);
        istar_d = istar; set_start(1'b1); clear3 = clr; sc = cyc;
        @(negedge clk);
        set_start(1'b0); clear3 = 1'b0; istar_d = 8'($urandom);
        check("ready_after_start", cur_ready(), 1);
        check("busy_after_start", cur_busy(), 1);
        send_words(8 * wps_sel(s), gapmax, base, poke);
        wait_done(dn0);
        @(negedge clk);
        check("busy_low_after_done", cur_busy(), 0);
        // Words offered while not ready must be ignored.
        repeat (3) begin
            valid_d = 1'b1; data_d = $urandom;
            @(negedge clk);
        end
        valid_d = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_load(input string tag, input int s, input int istar, input logic [31:0] base,
                              input int wr0, input int nd0, input int dn0);
        int nw;
        int got;
        nw = 8 * wps_sel(s);
        got = wr_addr_q.size() - wr0;
        check({tag, "_nwrites"}, got, nw);
        for (int k = 0; k < nw && k < got; k++) begin
            check({tag, "_addr"}, wr_addr_q[wr0 + k], k);
            check({tag, "_seed"}, wr_seed_q[wr0 + k], base + 32'(k));
        end
        check({tag, "_nnodes"}, nd_idx_q.size() - nd0, 8);
        for (int l = 1; l <= 8 && (nd0 + l - 1) < nd_idx_q.size(); l++) begin
            check({tag, "_node_idx"}, nd_idx_q[nd0 + l - 1], model_node(istar, l));
            check({tag, "_node_lvl"}, nd_lvl_q[nd0 + l - 1], l);
        end
        check({tag, "_done_once"}, done_cnt - dn0, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", bus1.o_data_ready, 0);
        check("rst_seed",  bus1.o_path_seed, 0);
        check("rst_addr",  bus1.o_path_addr, 0);
        check("rst_wen",   bus1.o_path_wen, 0);
        check("rst_nidx",  bus1.o_node_idx, 0);
        check("rst_nlvl",  bus1.o_node_level, 0);
        check("rst_nwen",  bus1.o_node_wen, 0);
        check("rst_busy",  bus1.o_busy, 0);
        check("rst_done",  bus1.o_done, 0);
    endtask

    typedef struct {
        logic [7:0]      istar;
        logic [0:7][8:0] nodes;
    } vec_t;

    initial begin
        vec_t vecs [3];
        int   sc, wr0, nd0, dn0, b0;
        logic [7:0]  ri;
        logic [31:0] rb;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [3];
        int   sc, wr0, nd0, dn0, b0, rs;
        logic [7:0]  ri;
        logic [31:0] rb;

        vecs[0].istar = 8'd8;
        vecs[0].nodes = {9'd3, 9'd5, 9'd9, 9'd17, 9'd32, 9'd67, 9'd133, 9'd265};
        vecs[1].istar = 8'd0;
        vecs[1].nodes = {9'd3, 9'd5, 9'd9, 9'd17, 9'd33, 9'd65, 9'd129, 9'd257};
        vecs[2].istar = 8'd255;
        vecs[2].nodes = {9'd2, 9'd6, 9'd14, 9'd30, 9'd62, 9'd126, 9'd254, 9'd510};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Table vectors: L1, contiguous words 0..31.
        for (int i = 0; i < 3; i++) begin
            wr0 = wr_addr_q.size(); nd0 = nd_idx_q.size(); dn0 = done_cnt;
            run_load(1, vecs[i].istar, 0, 32'h0, -1, 1'b0, sc);
            check("l1_latency", done_cyc - sc, 8 * WPS1 + 2);
            for (int l = 0; l < 8 && (nd0 + l) < nd_idx_q.size(); l++)
                check("table_node", nd_idx_q[nd0 + l], vecs[i].nodes[l]);
            check_load("table", 1, int'(vecs[i].istar), 32'h0, wr0, nd0, dn0);
        end

        // Randomized loads with valid gaps of 0..3 cycles on L5 and L1.
        for (int r = 0; r < 4; r++) begin
            rs = (r % 2 == 0) ? 5 : 1;
            ri = 8'($urandom); rb = $urandom;
            wr0 = wr_addr_q.size(); nd0 = nd_idx_q.size(); dn0 = done_cnt;
            run_load(rs, ri, 3, rb, -1, 1'b0, sc);
            check_load("rand", rs, int'(ri), rb, wr0, nd0, dn0);
        end

        // i_start pulsed mid-LOAD must be ignored.
        wr0 = wr_addr_q.size(); nd0 = nd_idx_q.size(); dn0 = done_cnt;
        run_load(1, 8'd77, 0, 32'h1000, 10, 1'b0, sc);
        check_load("midstart", 1, 77, 32'h1000, wr0, nd0, dn0);

        // Reset after word 13, then a fresh load starting at address 0.
        sel = 1;
        @(negedge clk);
        istar_d = 8'd5; set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        send_words(13, 0, 32'hA0, -1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        wr0 = wr_addr_q.size(); nd0 = nd_idx_q.size(); dn0 = done_cnt;
        run_load(1, 8'd200, 0, 32'h500, -1, 1'b0, sc);
        check("reload_first_addr", (wr_addr_q.size() > wr0) ? wr_addr_q[wr0] : -1, 0);
        check_load("reload", 1, 200, 32'h500, wr0, nd0, dn0);

        // L3: i_start together with i_clear starts a load.
        wr0 = wr_addr_q.size(); nd0 = nd_idx_q.size(); dn0 = done_cnt;
        run_load(3, 8'd33, 1, 32'h7700, -1, 1'b1, sc);
        check_load("start_wins", 3, 33, 32'h7700, wr0, nd0, dn0);

        // L3: i_clear alone in IDLE.
        sel = 3;
        wr0 = wr_addr_q.size(); dn0 = done_cnt; b0 = busy3_cnt;
        @(negedge clk);
        clear3 = 1'b1;
        @(negedge clk);
        clear3 = 1'b0;
`ifdef SIBLING_PATH_ZEROIZE_EN
        wait_done(dn0);
        repeat (3) @(negedge clk);
        check("zero_nwrites", wr_addr_q.size() - wr0, 8 * WPS3);
        for (int k = 0; k < 8 * int'(WPS3) && (wr0 + k) < wr_addr_q.size(); k++) begin
            check("zero_addr", wr_addr_q[wr0 + k], k);
            check("zero_seed", wr_seed_q[wr0 + k], 0);
        end
        check("zero_done_once", done_cnt - dn0, 1);
        check("zero_done_gap", done_cyc - last_wr_cyc, 1);
`else
        repeat (60) @(negedge clk);
        check("noclr_nwrites", wr_addr_q.size() - wr0, 0);
        check("noclr_busy", busy3_cnt - b0, 0);
        check("noclr_done", done_cnt - dn0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
